pattern_tx: RTL and testbench

Serial pattern transmitter: on a start request, captures a WIDTH-bit pattern and repetition count, then shifts the pattern out MSB-first on a one-bit serial line, one bit per clock, for the requested number of repetitions. It is the source side of the serial sequence-detection path: its `y`/`valid` output drives the `x` input of the 1101 sequence detectors and of the other serial-pattern receivers, both in benches and on-chip.

---
 rtl/pattern_tx_pkg.sv | 20 ++
 rtl/pattern_tx_piso_shreg.sv | 29 ++
 rtl/pattern_tx.sv | 161 ++++++++++++++++
 tb/tb_pattern_tx.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/pattern_tx_pkg.sv
// pattern_tx_pkg: state encoding for the serial pattern transmitter and the
// found/notfound levels shared with the serial sequence detectors it feeds.
package pattern_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic FOUND    = 1'b1;
  localparam logic NOTFOUND = 1'b0;

  // Counter width for a count range of n values; never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pattern_tx_piso_shreg.sv
// piso_shreg: WIDTH-bit parallel-in/serial-out shift register. Load wins over
// shift; the MSB is the serial output and zeros enter at the LSB.
module piso_shreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] sr;

  // Parallel load or shift-left by one; cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[WIDTH-2:0], 1'b0};
    end
  end

  assign sout = sr[WIDTH-1];

endmodule

// File: rtl/pattern_tx.sv
// pattern_tx: serial pattern transmitter. Captures pat/reps on an accepted
// start and sends the pattern MSB-first, one bit per clock, reps times.
// Optional feature macro: PATTERN_TX_GAP_EN inserts GAP_LEN idle cycles
// between repetitions (GAP state and gap counter exist only when defined).
//
// Handshake: start is a level request sampled only while the FSM is in IDLE;
// the rising edge that sees start=1 in IDLE accepts it and captures pat/reps.
// start in any other state is ignored. valid marks cycles where y is a
// pattern bit; done is a one-cycle pulse; busy covers SHIFT, GAP and DONE.
module pattern_tx
  import pattern_tx_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int CNT_W   = 4,
  parameter int GAP_LEN = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pat,
  input  logic [CNT_W-1:0] reps,
  output logic             y,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output state_t           dbg_state
);

  localparam int BIT_W = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q;
  logic [CNT_W-1:0] rep_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             sr_load, sr_shift, sr_msb;
  logic             cnt_reload, cnt_dec, rep_capture, rep_dec;
  logic [WIDTH-1:0] sr_din;

`ifdef PATTERN_TX_GAP_EN
  localparam int GAP_W = cnt_width(GAP_LEN);
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_reload, gap_dec;
`else
  logic unused_gap_len;
  assign unused_gap_len = (GAP_LEN != 0);
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and datapath controls.
  always_comb begin
    state_d     = state_q;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    cnt_reload  = 1'b0;
    cnt_dec     = 1'b0;
    rep_capture = 1'b0;
    rep_dec     = 1'b0;
`ifdef PATTERN_TX_GAP_EN
    gap_reload  = 1'b0;
    gap_dec     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          rep_capture = 1'b1;
          if (reps != '0) begin
            state_d    = SHIFT;
            sr_load    = 1'b1;
            cnt_reload = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        if (bit_cnt == '0) begin
          rep_dec = 1'b1;
          if (rep_cnt == CNT_W'(1)) begin
            state_d = DONE;
          end else begin
`ifdef PATTERN_TX_GAP_EN
            state_d    = GAP;
            gap_reload = 1'b1;
`else
            sr_load    = 1'b1;
            cnt_reload = 1'b1;
`endif
          end
        end else begin
          sr_shift = 1'b1;
          cnt_dec  = 1'b1;
        end
      end
`ifdef PATTERN_TX_GAP_EN
      GAP: begin
        if (gap_cnt == '0) begin
          state_d    = SHIFT;
          sr_load    = 1'b1;
          cnt_reload = 1'b1;
        end else begin
          gap_dec = 1'b1;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Captured pattern, remaining-repetition count and bit counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q   <= '0;
      rep_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      if (rep_capture) begin
        pat_q   <= pat;
        rep_cnt <= reps;
      end else if (rep_dec) begin
        rep_cnt <= rep_cnt - CNT_W'(1);
      end
      if (cnt_reload)   bit_cnt <= BIT_W'(WIDTH - 1);
      else if (cnt_dec) bit_cnt <= bit_cnt - BIT_W'(1);
    end
  end

`ifdef PATTERN_TX_GAP_EN
  // Idle-cycle counter between repetitions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          gap_cnt <= '0;
    else if (gap_reload) gap_cnt <= GAP_W'(GAP_LEN - 1);
    else if (gap_dec)    gap_cnt <= gap_cnt - GAP_W'(1);
  end
`endif

  // The first load takes the live input; reloads use the captured copy.
  assign sr_din = (state_q == IDLE) ? pat : pat_q;

  piso_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk   (clk),
    .reset (reset),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (sr_din),
    .sout  (sr_msb)
  );

  // Outputs decoded from registered state only.
  assign valid     = (state_q == SHIFT);
  assign y         = valid & sr_msb;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pattern_tx.sv
// tb_pattern_tx: directed bench for pattern_tx with a per-cycle expected queue
// of {busy, valid, y, done} built from pat/reps (and GAP_LEN when
// PATTERN_TX_GAP_EN is defined).
module tb_pattern_tx;
  import pattern_tx_pkg::*;

  localparam int WIDTH   = 4;
  localparam int CNT_W   = 4;
  localparam int GAP_LEN = 2;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] pat;
  logic [CNT_W-1:0] reps;
  logic             y, valid, busy, done;
  state_t           dbg_state;

  logic [3:0]       exp_q[$];
  logic [3:0]       det_sr;
  int               n_checks = 0;
  int               n_pass   = 0;

  pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP_LEN(GAP_LEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pat       (pat),
    .reps      (reps),
    .y         (y),
    .valid     (valid),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // Drive one transfer starting #1 after a clock edge. ign_a/ign_b: cycles in
  // which start is pulsed (must be ignored). rst_at: cycle in which reset is
  // asserted mid-cycle (0 = never).
  task automatic run_xfer(input logic [WIDTH-1:0] p, input logic [CNT_W-1:0] r,
                          input int ign_a, input int ign_b, input int rst_at);
    int         len;
    logic [3:0] obs;
    exp_q.delete();
    for (int i = 0; i < int'(r); i++) begin
      for (int b = WIDTH - 1; b >= 0; b--) exp_q.push_back({1'b1, 1'b1, p[b], 1'b0});
`ifdef PATTERN_TX_GAP_EN
      if (i < int'(r) - 1)
        for (int g = 0; g < GAP_LEN; g++) exp_q.push_back(4'b1000);
`endif
    end
    exp_q.push_back(4'b1001);
    exp_q.push_back(4'b0000);
    len = exp_q.size();
    pat = p; reps = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pat   = WIDTH'($urandom_range(0, 15));
    reps  = CNT_W'($urandom_range(0, 15));
    for (int c = 1; c <= len; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      obs = {busy, valid, y, done};
      if (valid) det_sr = {det_sr[2:0], y};
      check($sformatf("xfer_p%b_r%0d_c%0d", p, r, c), obs, exp_q.pop_front());
      if (c == rst_at) begin
        #3 reset = 1'b0;
        #1 check("reset_mid_outputs", {busy, valid, y, done}, 4'b0000);
        check("reset_mid_state", {2'b00, dbg_state}, {2'b00, IDLE});
        exp_q.delete();
        return;
      end
      start = (c == ign_a || c == ign_b);
      if (start) begin
        pat  = WIDTH'($urandom_range(0, 15));
        reps = CNT_W'($urandom_range(1, 15));
      end
    end
    start = 1'b0;
  endtask

  // Directed sequence
  initial begin
    reset = 1'b0; start = 1'b1; pat = 4'b1111; reps = 4'd1; det_sr = '0;
    #1 check("reset_outputs_t1", {busy, valid, y, done}, 4'b0000);
    repeat (3) begin
      @(posedge clk); #1;
      check("reset_held_outputs", {busy, valid, y, done}, 4'b0000);
    end
    start = 1'b0; reset = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("idle_after_reset", {busy, valid, y, done}, 4'b0000);
    end

    // Single repetition, fed to a 1101 detector model.
    det_sr = '0;
    run_xfer(4'b1101, 4'd1, 0, 0, 0);
    check("detector_found", {3'b000, (det_sr == 4'b1101) ? FOUND : NOTFOUND}, {3'b000, FOUND});

    // Three repetitions, starts during cycle 3 and the DONE cycle ignored.
    run_xfer(4'b1101, 4'd3, 3, 13, 0);

    // Two repetitions (gap inserted when compiled in).
    run_xfer(4'b1101, 4'd2, 0, 0, 0);

    // Zero repetitions: straight to DONE.
    run_xfer(4'b0110, 4'd0, 0, 0, 0);

    // Random patterns, short repetition counts.
    for (int t = 0; t < 3; t++)
      run_xfer(WIDTH'($urandom_range(0, 15)), CNT_W'($urandom_range(1, 3)), 0, 0, 0);

    // Reset during bit 3, then recover.
    run_xfer(4'b1011, 4'd2, 0, 0, 3);
    repeat (2) begin
      @(posedge clk); #1;
      check("reset_mid_held", {busy, valid, y, done}, 4'b0000);
    end
    reset = 1'b1; start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_after_mid_reset", {busy, valid, y, done}, 4'b0000);
    end
    det_sr = '0;
    run_xfer(4'b1101, 4'd1, 0, 0, 0);
    check("detector_found_after_reset", {3'b000, (det_sr == 4'b1101) ? FOUND : NOTFOUND}, {3'b000, FOUND});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
